// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory-port arbiter: FSM state encoding and
// arbitration policy selectors.
package mem_arb_pkg;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_BURST = 2'd1,
    WR       = 2'd2
  } arb_state_t;

  // Arbitration policy selectors for the ARB_MODE parameter
  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

endpackage

// File: rtl/arb_picker.sv
// Combinational winner selection: fixed priority (lowest index) or
// round-robin starting from the channel after ptr.
module arb_picker #(
  parameter int NUM_CH = 2,
  parameter int PTR_W  = 1
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [PTR_W-1:0]  ptr,
  input  logic              mode,
  output logic [NUM_CH-1:0] winner
);

  // Scan the requests in policy order and keep the first hit as a one-hot winner
  // NOTE: every variable written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    int  idx;
    logic found;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    if (mode) begin
      for (int k = 1; k <= NUM_CH; k++) begin
        idx = (int'(ptr) + k) % NUM_CH;
        if (!found && req[idx]) begin
          winner[idx] = 1'b1;
          found       = 1'b1;
        end
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (!found && req[i]) begin
          winner[i] = 1'b1;
          found     = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates several cache-side channels onto one memory port. Reads are
// aligned bursts of BURST_LEN words, writes are single words. The winner's
// command is latched at grant and held until the transaction completes.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_CH    = 2,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int BURST_LEN = 8,
  parameter int ARB_MODE  = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        ch_req,
  input  logic [NUM_CH-1:0]        ch_write,
  input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
  input  logic [NUM_CH*DATA_W-1:0] ch_wdata,
  output logic [NUM_CH-1:0]        ch_grant,
  output logic [NUM_CH-1:0]        ch_valid,
  output logic [DATA_W-1:0]        ch_rdata,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic                     mem_ack,
  input  logic [DATA_W-1:0]        mem_rdata
);

  localparam int PTR_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int OFS_W  = $clog2(BURST_LEN * 2);

  // Clears the byte offset within one burst to form the aligned base address
  localparam logic [ADDR_W-1:0] BASE_MASK = {ADDR_W{1'b1}} << OFS_W;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

  arb_state_t          state_q, state_d;
  logic [NUM_CH-1:0]   grant_q;
  logic [NUM_CH-1:0]   valid_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [BEAT_W-1:0]   beat_q;
  logic [PTR_W-1:0]    ptr_q;
  logic [NUM_CH-1:0]   winner;
  logic [PTR_W-1:0]    win_idx;
  logic [PTR_W-1:0]    owner_idx;

  arb_picker #(
    .NUM_CH (NUM_CH),
    .PTR_W  (PTR_W)
  ) u_picker (
    .req    (ch_req),
    .ptr    (ptr_q),
    .mode   (ARB_MODE == ARB_RR),
    .winner (winner)
  );

  // Encode the one-hot winner and the current owner as channel indices
  always_comb begin
    win_idx   = '0;
    owner_idx = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (winner[i])  win_idx   = PTR_W'(i);
      if (grant_q[i]) owner_idx = PTR_W'(i);
    end
  end

  // Next-state logic: requests are only looked at in IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (|ch_req) state_d = ch_write[win_idx] ? WR : RD_BURST;
      RD_BURST: if (mem_ack && beat_q == LAST_BEAT) state_d = IDLE;
      WR:       if (mem_ack) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // State register
  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Command latch, beat counter, completion pulses and round-robin pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_q <= '0;
      valid_q <= '0;
      rdata_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      beat_q  <= '0;
      ptr_q   <= PTR_W'(NUM_CH - 1);
    end else begin
      valid_q <= '0;
      if (state_q == IDLE) begin
        if (|ch_req) begin
          grant_q <= winner;
          addr_q  <= ch_addr[win_idx*ADDR_W +: ADDR_W];
          wdata_q <= ch_wdata[win_idx*DATA_W +: DATA_W];
          beat_q  <= '0;
        end
      end else if (mem_ack) begin
        valid_q <= grant_q;
        rdata_q <= mem_rdata;
        beat_q  <= beat_q + BEAT_W'(1);
        if (state_d == IDLE) begin
          grant_q <= '0;
          ptr_q   <= owner_idx;
        end
      end
    end
  end

  // Memory command outputs derived from the latched transaction
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      RD_BURST: begin
        mem_req  = 1'b1;
        mem_addr = (addr_q & BASE_MASK) + ADDR_W'({beat_q, 1'b0});
      end
      WR: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
      end
      default: ;
    endcase
  end

  assign ch_grant = grant_q;
  assign ch_valid = valid_q;
  assign ch_rdata = rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter: one fixed-priority and one
// round-robin instance share the stimulus; sel_rr picks the active one.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel_rr = 1'b0;
  logic [1:0]  ch_req = '0;
  logic [1:0]  ch_write = '0;
  logic [31:0] ch_addr = '0;
  logic [31:0] ch_wdata = '0;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_rdata = '0;

  int n_checks = 0;
  int n_err    = 0;

  logic [1:0]  fp_req, rr_req, fp_grant, rr_grant, fp_valid, rr_valid;
  logic [15:0] fp_rdata, rr_rdata, fp_addr, rr_addr, fp_wdata, rr_wdata;
  logic        fp_ack, rr_ack, fp_mreq, rr_mreq, fp_we, rr_we;

  logic [1:0]  grant, valid;
  logic [15:0] rdata, maddr, mwdata;
  logic        mreq, mwe;

  assign fp_req = sel_rr ? 2'b00 : ch_req;
  assign rr_req = sel_rr ? ch_req : 2'b00;
  assign fp_ack = mem_ack & ~sel_rr;
  assign rr_ack = mem_ack & sel_rr;

  assign grant  = sel_rr ? rr_grant : fp_grant;
  assign valid  = sel_rr ? rr_valid : fp_valid;
  assign rdata  = sel_rr ? rr_rdata : fp_rdata;
  assign maddr  = sel_rr ? rr_addr  : fp_addr;
  assign mwdata = sel_rr ? rr_wdata : fp_wdata;
  assign mreq   = sel_rr ? rr_mreq  : fp_mreq;
  assign mwe    = sel_rr ? rr_we    : fp_we;

  mem_port_arbiter #(.ARB_MODE(0)) dut (
    .clk(clk), .rst(rst), .ch_req(fp_req), .ch_write(ch_write),
    .ch_addr(ch_addr), .ch_wdata(ch_wdata), .ch_grant(fp_grant),
    .ch_valid(fp_valid), .ch_rdata(fp_rdata), .mem_req(fp_mreq),
    .mem_we(fp_we), .mem_addr(fp_addr), .mem_wdata(fp_wdata),
    .mem_ack(fp_ack), .mem_rdata(mem_rdata)
  );

  mem_port_arbiter #(.ARB_MODE(1)) dut_rr (
    .clk(clk), .rst(rst), .ch_req(rr_req), .ch_write(ch_write),
    .ch_addr(ch_addr), .ch_wdata(ch_wdata), .ch_grant(rr_grant),
    .ch_valid(rr_valid), .ch_rdata(rr_rdata), .mem_req(rr_mreq),
    .mem_we(rr_we), .mem_addr(rr_addr), .mem_wdata(rr_wdata),
    .mem_ack(rr_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Serves nbeats read beats for channel ch, acking lat cycles after each beat
  task automatic run_read(input int ch, input logic [15:0] base, input int lat,
                          input int nbeats, input logic [15:0] dseed);
    logic [15:0] exp_addr;
    for (int k = 0; k < nbeats; k++) begin
      exp_addr = base + 16'(2 * k);
      check($sformatf("ch%0d beat%0d grant", ch, k), 32'(grant), 32'(1 << ch));
      check($sformatf("ch%0d beat%0d mem_req", ch, k), 32'(mreq), 32'd1);
      check($sformatf("ch%0d beat%0d mem_we", ch, k), 32'(mwe), 32'd0);
      check($sformatf("ch%0d beat%0d mem_addr", ch, k), 32'(maddr), 32'(exp_addr));
      repeat (lat - 1) tick();
      check($sformatf("ch%0d beat%0d no early valid", ch, k), 32'(valid), 32'd0);
      mem_ack   = 1'b1;
      mem_rdata = dseed + 16'(k);
      tick();
      mem_ack = 1'b0;
      check($sformatf("ch%0d beat%0d valid", ch, k), 32'(valid), 32'(1 << ch));
      check($sformatf("ch%0d beat%0d rdata", ch, k), 32'(rdata), 32'(dseed + 16'(k)));
    end
    if (nbeats == 8) begin
      check($sformatf("ch%0d burst done grant", ch), 32'(grant), 32'd0);
      check($sformatf("ch%0d burst done mem_req", ch), 32'(mreq), 32'd0);
    end
  endtask

  initial begin
    // Reset state
    tick();
    check("reset grant", 32'(grant), 32'd0);
    check("reset valid", 32'(valid), 32'd0);
    check("reset rdata", 32'(rdata), 32'd0);
    check("reset mem_req", 32'(mreq), 32'd0);
    check("reset mem_we", 32'(mwe), 32'd0);
    check("reset mem_addr", 32'(maddr), 32'd0);
    check("reset mem_wdata", 32'(mwdata), 32'd0);
    rst = 1'b0;
    tick();

    // ch0 read at 0x0006, ack 4 cycles after each beat; request and address
    // change after grant must not disturb the burst
    ch_req = 2'b01;
    ch_addr[15:0] = 16'h0006;
    tick();
    check("s1 grant latency", 32'(grant), 32'h1);
    ch_req = 2'b00;
    ch_addr[15:0] = 16'hAAAA;
    run_read(0, 16'h0000, 4, 8, 16'h1000);

    // Fixed priority: both request, ch0 first, ch1 after one IDLE cycle
    ch_req = 2'b11;
    ch_addr = {16'h0212, 16'h0100};
    tick();
    check("s2 ch0 wins", 32'(grant), 32'h1);
    ch_req = 2'b10;
    run_read(0, 16'h0100, 2, 8, 16'h2000);
    tick();
    check("s2 ch1 granted", 32'(grant), 32'h2);
    ch_req = 2'b00;
    run_read(1, 16'h0210, 2, 8, 16'h3000);

    // ch1 single-word write; write data changes after grant are ignored
    ch_req = 2'b10;
    ch_write = 2'b10;
    ch_addr[31:16] = 16'h0040;
    ch_wdata[31:16] = 16'hBEEF;
    tick();
    check("wr grant", 32'(grant), 32'h2);
    check("wr mem_we", 32'(mwe), 32'd1);
    check("wr mem_addr", 32'(maddr), 32'h0040);
    ch_req = 2'b00;
    ch_wdata[31:16] = 16'h0000;
    tick();
    check("wr mem_wdata", 32'(mwdata), 32'hBEEF);
    check("wr no early valid", 32'(valid), 32'd0);
    mem_ack = 1'b1;
    mem_rdata = 16'h5A5A;
    tick();
    mem_ack = 1'b0;
    check("wr valid", 32'(valid), 32'h2);
    check("wr back to idle grant", 32'(grant), 32'd0);
    check("wr idle mem_we", 32'(mwe), 32'd0);
    check("wr idle mem_wdata", 32'(mwdata), 32'd0);
    tick();
    check("wr single pulse", 32'(valid), 32'd0);
    ch_write = 2'b00;

    // mem_ack in IDLE is ignored and ch_rdata holds its last value
    mem_ack = 1'b1;
    mem_rdata = 16'h1234;
    tick();
    mem_ack = 1'b0;
    check("idle ack valid", 32'(valid), 32'd0);
    check("idle ack rdata hold", 32'(rdata), 32'h5A5A);

    // Top-of-memory burst stays within its aligned block
    ch_req = 2'b01;
    ch_addr[15:0] = 16'hFFF6;
    tick();
    ch_req = 2'b00;
    run_read(0, 16'hFFF0, 2, 8, 16'h4000);

    // Reset after beat 3 of a burst, then a fresh burst from beat 0
    ch_req = 2'b01;
    ch_addr[15:0] = 16'h0020;
    tick();
    run_read(0, 16'h0020, 2, 4, 16'h5000);
    rst = 1'b1;
    ch_req = 2'b00;
    #1;
    check("mid rst grant", 32'(grant), 32'd0);
    check("mid rst valid", 32'(valid), 32'd0);
    check("mid rst rdata", 32'(rdata), 32'd0);
    check("mid rst mem_req", 32'(mreq), 32'd0);
    check("mid rst mem_addr", 32'(maddr), 32'd0);
    tick();
    rst = 1'b0;
    mem_ack = 1'b1;
    tick();
    tick();
    mem_ack = 1'b0;
    check("post rst no valid", 32'(valid), 32'd0);
    ch_req = 2'b01;
    tick();
    ch_req = 2'b00;
    run_read(0, 16'h0020, 2, 8, 16'h6000);

    // Round-robin: both hold requests, grants alternate 0,1,0,1
    sel_rr = 1'b1;
    ch_addr = {16'h0400, 16'h0300};
    ch_req = 2'b11;
    for (int t = 0; t < 4; t++) begin
      tick();
      if (t == 3) ch_req = 2'b00;
      run_read(t % 2, (t % 2 == 0) ? 16'h0300 : 16'h0400, 2, 8, 16'(16'h7000 + 16'(t * 16'h100)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, number of cache-side channels (1..8; channel 0 = I-cache, 1 = D-cache).
REQ-002 SHALL have parameter ADDR_W, default 16, byte-address width.
REQ-003 SHALL have parameter DATA_W, default 16, word width; word = 2 bytes.
REQ-004 SHALL have parameter BURST_LEN, default 8, words per read burst (power of 2, 1..16).
REQ-005 SHALL have parameter ARB_MODE, default 0, arbitration policy: 0 = fixed priority (lowest index wins), 1 = round-robin.
REQ-006 SHALL have ports: clk  in  1  clock; all state updates on rising edge.
REQ-007 SHALL have ports: rst  in  1  reset; asynchronous, active-high.
REQ-008 SHALL have ports: ch_req  in  NUM_CH  per-channel access request.
REQ-009 SHALL have ports: ch_write  in  NUM_CH  per-channel 1 = single-word write, 0 = read burst.
REQ-010 SHALL have ports: ch_addr  in  NUM_CH*ADDR_W  packed per-channel address (channel i at bits [i*ADDR_W +: ADDR_W]).
REQ-011 SHALL have ports: ch_wdata  in  NUM_CH*DATA_W  packed per-channel write data.
REQ-012 SHALL have ports: ch_grant  out  NUM_CH  one-hot owner of the memory port; all-zero when idle.
REQ-013 SHALL have ports: ch_valid  out  NUM_CH  one-cycle pulse per completed beat, owner only.
REQ-014 SHALL have ports: ch_rdata  out  DATA_W  read data shared by all channels, qualified by ch_valid.
REQ-015 SHALL have ports: mem_req  out  1, mem_we  out  1, mem_addr  out  ADDR_W, mem_wdata  out  DATA_W  memory command.
REQ-016 SHALL have ports: mem_ack  in  1, mem_rdata  in  DATA_W  memory completion for the current command.

Function
REQ-017 SHALL implement states IDLE, RD_BURST, WR; IDLE -> RD_BURST/WR on winning request; RD_BURST -> IDLE after beat BURST_LEN-1 acked; WR -> IDLE on ack.
REQ-018 SHALL sample ch_req in IDLE only; winner's ch_write, ch_addr, ch_wdata latched on the grant edge; later changes ignored until IDLE.
REQ-019 SHALL assert ch_grant and mem_req the cycle after the winning request is sampled (one-cycle grant latency); both held until return to IDLE.
REQ-020 SHALL, in ARB_MODE 1, search from the channel after the last granted one; pointer updates only when a transaction completes; reset pointer = NUM_CH-1 (channel 0 first).
REQ-021 SHALL form the read base address by clearing the low log2(BURST_LEN*2) bits of the latched address; beat k address = base + 2k, ADDR_W-bit modular.
REQ-022 SHALL drive mem_addr = current beat address, mem_we = 1 only in WR, mem_wdata = latched write data in WR, else 0.
REQ-023 SHALL, on mem_ack high in a busy state, register ch_valid[owner] = 1 and ch_rdata = mem_rdata for exactly the next cycle, and advance the beat counter on the same edge.
REQ-024 SHALL ignore mem_ack in IDLE; ch_valid stays 0.
REQ-025 SHALL complete a granted read burst even if ch_req drops mid-burst (no abort).
REQ-026 SHALL return to IDLE after the last ack and may re-grant on the following sample; minimum one IDLE cycle between transactions.
REQ-027 SHALL hold ch_rdata stable when ch_valid is 0 (no update without ack).
REQ-028 SHALL, with BURST_LEN = 1, treat a read as a single beat.

Reset
REQ-029 SHALL on rst force state IDLE, beat counter 0, RR pointer NUM_CH-1, ch_grant 0, ch_valid 0, ch_rdata 0, mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0, asynchronously.
REQ-030 SHALL abandon any in-flight transaction on reset mid-burst; no ch_valid pulse for it after reset release.

Structure
REQ-031 SHALL place the state encoding and ARB_MODE constants (ARB_FIXED = 0, ARB_RR = 1) in shared package mem_arb_pkg.
REQ-032 SHALL factor winner selection into one combinational sub-module arb_picker (inputs requests, pointer, mode; output one-hot winner).

Verification
REQ-033 SHALL cover: ch0 read 0x0006, memory ack 4 cycles after each beat -> grant[0] next cycle, 8 valid pulses, mem_addr 0x0000..0x000E step 2.
REQ-034 SHALL cover: ch0 and ch1 request same cycle, ARB_MODE 0 -> ch0 served first, ch1 granted after ch0's 8th ack plus one IDLE cycle.
REQ-035 SHALL cover: ARB_MODE 1, both channels holding requests for 4 transactions -> grants alternate 0,1,0,1.
REQ-036 SHALL cover: ch1 write addr 0x0040 data 0xBEEF -> mem_we 1, mem_addr 0x0040, mem_wdata 0xBEEF, one ch_valid[1] pulse, back to IDLE.
REQ-037 SHALL cover: rst asserted after beat 3 of a ch0 burst -> all outputs 0 immediately; no further ch_valid; fresh request then starts at beat 0.
REQ-038 SHALL cover: ch0 read 0xFFF6 -> burst addresses 0xFFF0..0xFFFE, no wrap past 0xFFFE.
